// File: rtl/jt10_adpcm_rom_pkg.sv
// Shared types and widths for the jt10 ADPCM ROM responder.
package jt10_adpcm_rom_pkg;
    localparam int BYTE_AW = 26;
    localparam int WORD_AW = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2
    } state_t;
endpackage

// File: rtl/jt10_adpcm_rom_ch.sv
// One ADPCM fetch channel: input registers, fetch-event detect, pending target,
// one-word cache and the byte returned to jt10.
module jt10_adpcm_rom_ch
    import jt10_adpcm_rom_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTE_AW-1:0] byte_addr,
    input  logic               roe_n,
    input  logic               grant,
    input  logic               done,
    input  logic [15:0]        rdata,
    output logic               req,
    output logic [WORD_AW-1:0] req_word,
    output logic               hit,
    output logic [7:0]         data_out
);
    logic [BYTE_AW-1:0] addr_q, addr_d, target, fl_addr, req_addr;
    logic               roe_q, roe_d, pending, valid, ev, miss;
    logic [WORD_AW-1:0] tag;
    logic [15:0]        cache;

    assign ev       = ~roe_q & (roe_d | (addr_q != addr_d));
    assign hit      = ev & valid & (tag == addr_q[BYTE_AW-1:1]);
    assign miss     = ev & ~hit;
    // A fresh miss bypasses the pending register so it can be granted in the same cycle.
    assign req      = pending | miss;
    assign req_addr = miss ? addr_q : target;
    assign req_word = req_addr[BYTE_AW-1:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            addr_d   <= '0;
            roe_q    <= 1'b1;
            roe_d    <= 1'b1;
            target   <= '0;
            fl_addr  <= '0;
            pending  <= 1'b0;
            valid    <= 1'b0;
            tag      <= '0;
            cache    <= '0;
            data_out <= '0;
        end else begin
            addr_q <= byte_addr;
            roe_q  <= roe_n;
            addr_d <= addr_q;
            roe_d  <= roe_q;
            if (miss) target <= addr_q;
            if (grant) begin
                pending <= 1'b0;
                fl_addr <= req_addr;
            end else if (miss) begin
                pending <= 1'b1;
            end
            if (done) begin
                tag   <= fl_addr[BYTE_AW-1:1];
                cache <= rdata;
                valid <= 1'b1;
            end
            // A hit is the newer fetch, so it wins the output over a completing read.
            if (hit)
                data_out <= addr_q[0] ? cache[15:8] : cache[7:0];
            else if (done)
                data_out <= fl_addr[0] ? rdata[15:8] : rdata[7:0];
        end
    end
endmodule

// File: rtl/jt10_adpcm_rom.sv
// YM2610 ADPCM-A/B ROM responder: two cached fetch channels sharing one
// 16-bit req/ack memory port through a round-robin arbiter.
module jt10_adpcm_rom
    import jt10_adpcm_rom_pkg::*;
#(
    parameter logic [BYTE_AW-1:0] A_BASE = 26'h0000000,
    parameter logic [BYTE_AW-1:0] B_BASE = 26'h2000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [19:0]        adpcma_addr,
    input  logic [4:0]         adpcma_bank,
    input  logic               adpcma_roe_n,
    output logic [7:0]         adpcma_data,
    input  logic [23:0]        adpcmb_addr,
    input  logic               adpcmb_roe_n,
    output logic [7:0]         adpcmb_data,
    output logic [WORD_AW-1:0] mem_addr,
    output logic               mem_req,
    input  logic               mem_ack,
    input  logic [15:0]        mem_rdata
);
    state_t             state, state_nx;
    logic               last_b;
    logic               req_a, req_b, hit_a, hit_b;
    logic               grant_a, grant_b, done_a, done_b;
    logic [WORD_AW-1:0] word_a, word_b;
    logic [BYTE_AW-1:0] byte_a, byte_b;

    assign byte_a = A_BASE + {1'b0, adpcma_bank, adpcma_addr};
    assign byte_b = B_BASE + {2'b00, adpcmb_addr};

    jt10_adpcm_rom_ch u_ch_a (
        .clk(clk), .rst(rst), .byte_addr(byte_a), .roe_n(adpcma_roe_n),
        .grant(grant_a), .done(done_a), .rdata(mem_rdata),
        .req(req_a), .req_word(word_a), .hit(hit_a), .data_out(adpcma_data)
    );

    jt10_adpcm_rom_ch u_ch_b (
        .clk(clk), .rst(rst), .byte_addr(byte_b), .roe_n(adpcmb_roe_n),
        .grant(grant_b), .done(done_b), .rdata(mem_rdata),
        .req(req_b), .req_word(word_b), .hit(hit_b), .data_out(adpcmb_data)
    );

    always_comb begin
        state_nx = state;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        done_a   = 1'b0;
        done_b   = 1'b0;
        case (state)
            IDLE: begin
                if (req_a && (!req_b || last_b)) begin
                    grant_a  = 1'b1;
                    state_nx = RD_A;
                end else if (req_b) begin
                    grant_b  = 1'b1;
                    state_nx = RD_B;
                end
            end
            RD_A: if (mem_ack) begin
                done_a   = 1'b1;
                state_nx = IDLE;
            end
            RD_B: if (mem_ack) begin
                done_b   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            last_b   <= 1'b1;
        end else begin
            state <= state_nx;
            if (grant_a) begin
                mem_req  <= 1'b1;
                mem_addr <= word_a;
                last_b   <= 1'b0;
            end else if (grant_b) begin
                mem_req  <= 1'b1;
                mem_addr <= word_b;
                last_b   <= 1'b1;
            end else if (done_a || done_b) begin
                mem_req <= 1'b0;
            end
        end
    end

    // Hits are resolved entirely inside the channels.
    logic unused_hits;
    assign unused_hits = hit_a ^ hit_b;
endmodule

// File: tb/tb_jt10_adpcm_rom.sv
// Directed bench for jt10_adpcm_rom: hit/miss latency, arbitration, refetch, reset abort, stall.
module tb_jt10_adpcm_rom;
    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] adpcma_addr;
    logic [4:0]  adpcma_bank;
    logic        adpcma_roe_n;
    logic [7:0]  adpcma_data;
    logic [23:0] adpcmb_addr;
    logic        adpcmb_roe_n;
    logic [7:0]  adpcmb_data;
    logic [24:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jt10_adpcm_rom dut (
        .clk(clk), .rst(rst),
        .adpcma_addr(adpcma_addr), .adpcma_bank(adpcma_bank),
        .adpcma_roe_n(adpcma_roe_n), .adpcma_data(adpcma_data),
        .adpcmb_addr(adpcmb_addr), .adpcmb_roe_n(adpcmb_roe_n),
        .adpcmb_data(adpcmb_data),
        .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ack(input logic [15:0] d);
        mem_ack   = 1'b1;
        mem_rdata = d;
        @(negedge clk);
        mem_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        adpcma_addr = '0; adpcma_bank = '0; adpcma_roe_n = 1'b1;
        adpcmb_addr = '0; adpcmb_roe_n = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        chk("rst_a_data", adpcma_data, 8'h00);
        chk("rst_b_data", adpcmb_data, 8'h00);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 25'h0);

        // A miss at byte 1
        adpcma_addr = 20'h00001; adpcma_roe_n = 1'b0;
        step(1);
        chk("miss_req_early", mem_req, 1'b0);
        step(1);
        chk("miss_req", mem_req, 1'b1);
        chk("miss_addr", mem_addr, 25'h0);
        ack(16'hBEEF);
        chk("miss_data", adpcma_data, 8'hBE);
        chk("miss_req_drop", mem_req, 1'b0);

        // A hit on the cached word
        adpcma_addr = 20'h00000;
        step(1);
        chk("hit_data_early", adpcma_data, 8'hBE);
        step(1);
        chk("hit_data", adpcma_data, 8'hEF);
        chk("hit_noreq", mem_req, 1'b0);

        // B alone so the next tie favours A
        adpcmb_addr = 24'h000040; adpcmb_roe_n = 1'b0;
        step(2);
        chk("b_req", mem_req, 1'b1);
        chk("b_addr", mem_addr, 25'h1000020);
        ack(16'h0102);
        chk("b_data", adpcmb_data, 8'h02);

        // Tie: A first
        adpcma_addr = 20'h00100; adpcmb_addr = 24'h000010;
        step(2);
        chk("tie1_addr_a", mem_addr, 25'h0000080);
        ack(16'h1234);
        chk("tie1_a_data", adpcma_data, 8'h34);
        chk("tie1_gap", mem_req, 1'b0);
        step(1);
        chk("tie1_req_b", mem_req, 1'b1);
        chk("tie1_addr_b", mem_addr, 25'h1000008);
        ack(16'h5678);
        chk("tie1_b_data", adpcmb_data, 8'h78);

        // A alone, then a tie: B first
        adpcma_addr = 20'h00200;
        step(2);
        chk("a2_addr", mem_addr, 25'h0000100);
        ack(16'hAA55);
        chk("a2_data", adpcma_data, 8'h55);
        adpcma_addr = 20'h00300; adpcmb_addr = 24'h000020;
        step(2);
        chk("tie2_addr_b", mem_addr, 25'h1000010);
        ack(16'h9988);
        chk("tie2_b_data", adpcmb_data, 8'h88);
        step(1);
        chk("tie2_addr_a", mem_addr, 25'h0000180);
        ack(16'h7766);
        chk("tie2_a_data", adpcma_data, 8'h66);

        // A changes during RD_A; B hits meanwhile
        adpcma_addr = 20'h00401;
        step(2);
        chk("rf_req", mem_req, 1'b1);
        chk("rf_addr1", mem_addr, 25'h0000200);
        adpcma_addr = 20'h00603; adpcmb_addr = 24'h000021;
        step(2);
        chk("rf_b_hit", adpcmb_data, 8'h99);
        chk("rf_addr_hold", mem_addr, 25'h0000200);
        step(1);
        ack(16'h1122);
        chk("rf_data1", adpcma_data, 8'h11);
        chk("rf_gap", mem_req, 1'b0);
        step(1);
        chk("rf_req2", mem_req, 1'b1);
        chk("rf_addr2", mem_addr, 25'h0000301);
        ack(16'h3344);
        chk("rf_data2", adpcma_data, 8'h33);

        // Stalled memory: request held stable
        adpcma_addr = 20'h00800;
        step(2);
        for (int i = 0; i < 100; i++) begin
            chk("stall_hold", {mem_req, mem_addr}, {1'b1, 25'h0000400});
            step(1);
        end
        ack(16'hCDAB);
        chk("stall_data", adpcma_data, 8'hAB);

        // Reset while a request is outstanding
        adpcma_addr = 20'h00A00;
        step(2);
        chk("rr_req", mem_req, 1'b1);
        rst = 1'b1; adpcma_roe_n = 1'b1; adpcmb_roe_n = 1'b1;
        step(1);
        chk("rr_req_drop", mem_req, 1'b0);
        chk("rr_addr", mem_addr, 25'h0);
        rst = 1'b0;
        step(1);
        ack(16'hFFFF);
        step(2);
        chk("rr_req_after", mem_req, 1'b0);
        chk("rr_a_data", adpcma_data, 8'h00);
        chk("rr_b_data", adpcmb_data, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
